// File: rtl/bus_read_sequencer.sv
// Scans a masked set of tri-state bus slots one cs at a time, capturing each word onto a valid/ready stream.
// Latency: SettleCycles+1 ticks of cs low per slot, one gap tick between slots; the stream stalls in OUTPUT until Ready.
module bus_read_sequencer #(
    parameter int NrOfBits     = 8,
    parameter int NrOfSlots    = 4,
    parameter int SlotBits     = 2,
    parameter int SettleCycles = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 Start,
    input  logic [NrOfSlots-1:0] SlotMask,
    input  logic [NrOfBits-1:0]  BusIn,
    output logic [NrOfSlots-1:0] cs,
    output logic [NrOfBits-1:0]  DataOut,
    output logic [SlotBits-1:0]  SlotOut,
    output logic                 Valid,
    input  logic                 Ready,
    output logic                 Busy,
    output logic                 Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_OUTPUT,
        S_GAP,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [NrOfSlots-1:0]   mask_q, mask_d;
    logic [SlotBits-1:0]    slot_q, slot_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [NrOfSlots-1:0]   cs_q, cs_d;
    logic [NrOfBits-1:0]    data_q, data_d;
    logic [SlotBits-1:0]    slot_out_q, slot_out_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SlotBits:0]      first_slot, next_slot;

    // MSB flags "found"; descending loop so the lowest qualifying index wins.
    function automatic logic [SlotBits:0] first_from(input logic [NrOfSlots-1:0] m, input int lo);
        logic [SlotBits:0] r;
        r = '0;
        for (int i = NrOfSlots - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) r = {1'b1, SlotBits'(i)};
        end
        return r;
    endfunction

    function automatic logic [NrOfSlots-1:0] cs_for(input logic [SlotBits-1:0] s);
        logic [NrOfSlots-1:0] c;
        c = '1;
        for (int i = 0; i < NrOfSlots; i++) begin
            c[i] = (SlotBits'(i) != s);
        end
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        cs_d       = cs_q;
        data_d     = data_q;
        slot_out_d = slot_out_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        first_slot = first_from(SlotMask, 0);
        next_slot  = first_from(mask_q, int'(slot_q) + 1);

        case (state_q)
            S_IDLE: begin
                if (Start && Tick) begin
                    mask_d = SlotMask;
                    busy_d = 1'b1;
                    if (first_slot[SlotBits]) begin
                        slot_d  = first_slot[SlotBits-1:0];
                        cs_d    = cs_for(first_slot[SlotBits-1:0]);
                        cnt_d   = '0;
                        state_d = S_SELECT;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_SELECT: begin
                if (Tick) begin
                    if (cnt_q == 4'(SettleCycles)) begin
                        data_d     = BusIn;
                        slot_out_d = slot_q;
                        valid_d    = 1'b1;
                        cs_d       = '1;
                        state_d    = S_OUTPUT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            // Handshake is deliberately not gated by Tick.
            S_OUTPUT: begin
                if (valid_q && Ready) begin
                    valid_d = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (Tick) begin
                    if (next_slot[SlotBits]) begin
                        slot_d  = next_slot[SlotBits-1:0];
                        cs_d    = cs_for(next_slot[SlotBits-1:0]);
                        cnt_d   = '0;
                        state_d = S_SELECT;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (Tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            slot_q     <= '0;
            cnt_q      <= '0;
            cs_q       <= '1;
            data_q     <= '0;
            slot_out_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            data_q     <= data_d;
            slot_out_q <= slot_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cs      = cs_q;
    assign DataOut = data_q;
    assign SlotOut = slot_out_q;
    assign Valid   = valid_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Bench for bus_read_sequencer: emulated register bus, scan-level reference model and directed scenarios.
module tb_bus_read_sequencer;

    localparam int NS  = 4;
    localparam int SET = 1;
    localparam logic [7:0] REGS [NS] = '{8'h11, 8'h22, 8'h33, 8'h44};

    logic       Clock = 1'b0;
    logic       Reset, Tick, Start, Ready;
    logic [3:0] SlotMask;
    logic [7:0] BusIn;
    logic [3:0] cs;
    logic [7:0] DataOut;
    logic [1:0] SlotOut;
    logic       Valid, Busy, Done;

    bus_read_sequencer #(.NrOfBits(8), .NrOfSlots(NS), .SlotBits(2), .SettleCycles(SET)) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .SlotMask(SlotMask),
        .BusIn(BusIn), .cs(cs), .DataOut(DataOut), .SlotOut(SlotOut), .Valid(Valid),
        .Ready(Ready), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // Registers on the bus: a selected register drives, contention or no driver gives X.
    always_comb begin : bus_drv
        int nd;
        nd = 0;
        BusIn = 8'hxx;
        for (int i = 0; i < NS; i++) begin
            if (cs[i] == 1'b0) begin
                nd++;
                BusIn = REGS[i];
            end
        end
        if (nd > 1) BusIn = 8'hxx;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scan-level model state.
    bit         mon_en = 0;
    bit         model_busy = 0;
    logic [3:0] model_mask = '0;
    int         exp_slot[$];
    logic [7:0] exp_dat[$];
    int         rcv_slot[$];
    logic [7:0] rcv_dat[$];
    int         done_cnt = 0;
    int         low_cycles[NS];
    bit         run_active = 0, run_abort = 0, prev_done = 0;
    int         run_idx = 0, run_ticks = 0;

    always @(negedge Clock) begin
        if (mon_en) begin : mon
            int nz, zi;
            nz = 0;
            zi = 0;
            for (int i = 0; i < NS; i++) begin
                if (cs[i] !== 1'b1) begin
                    nz++;
                    zi = i;
                end
            end
            chk("cs_single_low", 32'(nz <= 1), 32'd1);
            if (nz == 1) begin
                low_cycles[zi]++;
                if (run_active) begin
                    chk("cs_break_before_make", 32'(zi), 32'(run_idx));
                end else begin
                    run_active = 1;
                    run_idx    = zi;
                    run_ticks  = 0;
                    run_abort  = 0;
                    chk("cs_slot_in_mask", 32'(model_busy && model_mask[zi]), 32'd1);
                end
                chk("valid_with_cs_low", 32'(Valid), 32'd0);
            end else if (run_active) begin
                if (!run_abort) chk("cs_low_ticks", 32'(run_ticks), 32'(SET + 1));
                run_active = 0;
            end
            if (Valid) begin
                chk("valid_expected", 32'(exp_slot.size() > 0), 32'd1);
                if (exp_slot.size() > 0) begin
                    chk("slot_out", 32'(SlotOut), 32'(exp_slot[0]));
                    chk("data_out", 32'(DataOut), 32'(exp_dat[0]));
                end
            end
            if (Done) begin
                chk("done_legal", 32'(model_busy && exp_slot.size() == 0 && !prev_done && !Valid), 32'd1);
                done_cnt++;
                model_busy = 0;
            end
            chk("busy", 32'(Busy), 32'(model_busy));
            prev_done = Done;

            // Inputs now present take effect at the coming edge.
            if (Reset) begin
                model_busy = 0;
                model_mask = '0;
                exp_slot.delete();
                exp_dat.delete();
                if (run_active) run_abort = 1;
            end else begin
                if (run_active && Tick) run_ticks++;
                if (Valid && Ready && exp_slot.size() > 0) begin
                    rcv_slot.push_back(exp_slot.pop_front());
                    rcv_dat.push_back(DataOut);
                    void'(exp_dat.pop_front());
                end
                if (Start && Tick && !model_busy) begin
                    model_busy = 1;
                    model_mask = SlotMask;
                    for (int i = 0; i < NS; i++) begin
                        if (SlotMask[i]) begin
                            exp_slot.push_back(i);
                            exp_dat.push_back(REGS[i]);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_obs();
        rcv_slot.delete();
        rcv_dat.delete();
        for (int i = 0; i < NS; i++) low_cycles[i] = 0;
    endtask

    // One full scan; returns the clocks from Start acceptance until Done was seen.
    task automatic scan(input logic [3:0] m, input bit tick_alt, input int rdy_hold,
                        input bit inject, output int cyc);
        int  d0, vcnt;
        bit  fin;
        d0 = done_cnt;
        vcnt = 0;
        fin = 0;
        cyc = 0;
        clear_obs();
        SlotMask = m;
        Start = 1;
        Tick = 1;
        Ready = (rdy_hold == 0);
        step();
        for (int c = 0; c < 300 && !fin; c++) begin
            Tick = tick_alt ? ((c % 2) == 1) : 1'b1;
            if (inject && c == 3) begin
                Start = 1;
                SlotMask = 4'b0001;
            end else begin
                Start = 0;
            end
            if (Valid && rcv_slot.size() == 0) vcnt++;
            Ready = (rdy_hold == 0) || (rcv_slot.size() > 0) || (vcnt > rdy_hold);
            step();
            cyc++;
            if (done_cnt != d0) fin = 1;
        end
        chk("scan_timeout", 32'(fin), 32'd1);
        Start = 0;
        Ready = 0;
        Tick = 1;
        repeat (4) step();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("busy_after_scan", 32'(Busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, d0;
        Reset = 1;
        Tick = 0;
        Start = 0;
        Ready = 0;
        SlotMask = '0;
        repeat (2) step();
        chk("rst_cs", 32'(cs), 32'h0000000f);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_data", 32'(DataOut), 32'd0);
        chk("rst_slot", 32'(SlotOut), 32'd0);
        Reset = 0;
        mon_en = 1;
        step();

        // Full scan, no backpressure.
        scan(4'b1111, 1'b0, 0, 1'b0, cyc);
        chk("full_words", 32'(rcv_slot.size()), 32'd4);
        for (int i = 0; i < NS && i < rcv_slot.size(); i++) begin
            chk("full_slot", 32'(rcv_slot[i]), 32'(i));
            chk("full_data", 32'(rcv_dat[i]), 32'(8'h11 * (i + 1)));
            chk("full_low_cycles", 32'(low_cycles[i]), 32'd2);
        end

        // Sparse mask with five clocks of backpressure on the first word.
        scan(4'b1010, 1'b0, 5, 1'b0, cyc);
        chk("sparse_words", 32'(rcv_slot.size()), 32'd2);
        if (rcv_slot.size() == 2) begin
            chk("sparse_slot0", 32'(rcv_slot[0]), 32'd1);
            chk("sparse_data0", 32'(rcv_dat[0]), 32'h22);
            chk("sparse_slot1", 32'(rcv_slot[1]), 32'd3);
            chk("sparse_data1", 32'(rcv_dat[1]), 32'h44);
        end
        chk("sparse_no_slot0", 32'(low_cycles[0]), 32'd0);
        chk("sparse_no_slot2", 32'(low_cycles[2]), 32'd0);
        chk("sparse_low1", 32'(low_cycles[1]), 32'd2);

        // Empty mask.
        scan(4'b0000, 1'b0, 0, 1'b0, cyc);
        chk("empty_done_latency", 32'(cyc <= 3), 32'd1);
        chk("empty_words", 32'(rcv_slot.size()), 32'd0);
        chk("empty_no_cs", 32'(low_cycles[0] + low_cycles[1] + low_cycles[2] + low_cycles[3]), 32'd0);

        // Tick toggling with a stray Start and mask change mid-scan.
        scan(4'b1111, 1'b1, 0, 1'b1, cyc);
        chk("tick_words", 32'(rcv_slot.size()), 32'd4);
        if (rcv_slot.size() == 4) chk("tick_last_data", 32'(rcv_dat[3]), 32'h44);

        // Reset while slot 2 is selected.
        clear_obs();
        SlotMask = 4'b1111;
        Start = 1;
        Tick = 1;
        Ready = 1;
        step();
        Start = 0;
        for (int c = 0; c < 60 && cs !== 4'b1011; c++) step();
        chk("reach_slot2", 32'(cs), 32'h0000000b);
        Reset = 1;
        step();
        Reset = 0;
        chk("midrst_cs", 32'(cs), 32'h0000000f);
        chk("midrst_valid", 32'(Valid), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        d0 = done_cnt;
        repeat (5) step();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        scan(4'b1111, 1'b0, 0, 1'b0, cyc);
        chk("after_rst_words", 32'(rcv_slot.size()), 32'd4);
        if (rcv_slot.size() == 4) chk("after_rst_first", 32'(rcv_dat[0]), 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
